rc4_stream_cipher: RTL and testbench

Session controller and data-path front end for the RC4 keystream generator (`rc4_new_design`). It initiates a keystream generation:
- it drives `start`, `key` and `key_length` into the generator;
- it waits for `done` and captures the parallel `ckey` bus;
- it XORs the captured keystream, byte by byte, with a valid/ready plaintext stream to produce a valid/ready ciphertext stream.

It sits between the system data path and the generator, and owns the generator's start handshake.

---
 rtl/rc4_stream_cipher.sv | 133 +++++++++++++
 tb/tb_rc4_stream_cipher.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rc4_stream_cipher.sv
// RC4 session controller: owns the keystream generator's start handshake,
// captures the parallel keystream and XORs it onto a valid/ready byte stream.
module rc4_stream_cipher #(
   parameter int NUMS_OF_BYTES = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       go,
   input  logic [NUMS_OF_BYTES*8-1:0] key,
   input  logic [7:0]                 key_length,
   output logic                       busy,
   output logic                       session_done,
   output logic                       ks_start,
   output logic [NUMS_OF_BYTES*8-1:0] ks_key,
   output logic [7:0]                 ks_key_length,
   input  logic [NUMS_OF_BYTES*8-1:0] ks_ckey,
   input  logic                       ks_done,
   input  logic                       s_valid,
   input  logic [7:0]                 s_data,
   output logic                       s_ready,
   output logic                       m_valid,
   output logic [7:0]                 m_data,
   input  logic                       m_ready
);

   // state      | meaning
   // ST_IDLE    | waiting for go; key/length captured when it arrives
   // ST_WAIT_KS | ks_start held high until a rising edge of ks_done
   // ST_STREAM  | XOR plaintext with buffered keystream, byte 0 first

   localparam int         KW       = NUMS_OF_BYTES * 8;
   localparam logic [7:0] LAST_IDX = 8'(NUMS_OF_BYTES);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_KS = 2'd1,
      ST_STREAM  = 2'd2
   } state_t;

   state_t          r_state;
   logic [7:0]      r_idx;
   logic [KW-1:0]   r_buf;
   logic            r_done_q;
   logic            r_busy;
   logic            r_session_done;
   logic            r_ks_start;
   logic [KW-1:0]   r_ks_key;
   logic [7:0]      r_ks_key_length;
   logic            r_m_valid;
   logic [7:0]      r_m_data;

   logic            w_ks_rise;
   logic            w_s_ready;
   logic            w_in_xfer;
   logic            w_out_take;
   logic [7:0]      w_ks_byte;

   assign w_ks_rise  = ks_done && !r_done_q;
   assign w_s_ready  = (r_state == ST_STREAM) && (r_idx < LAST_IDX) && (!r_m_valid || m_ready);
   assign w_in_xfer  = s_valid && w_s_ready;
   assign w_out_take = r_m_valid && m_ready;

   always_comb begin
      w_ks_byte = '0;
      for (int i = 0; i < NUMS_OF_BYTES; i++) begin
         if (r_idx == 8'(i)) w_ks_byte = r_buf[i*8 +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_idx           <= '0;
         r_buf           <= '0;
         r_done_q        <= 1'b0;
         r_busy          <= 1'b0;
         r_session_done  <= 1'b0;
         r_ks_start      <= 1'b0;
         r_ks_key        <= '0;
         r_ks_key_length <= '0;
         r_m_valid       <= 1'b0;
         r_m_data        <= '0;
      end else begin
         r_done_q       <= ks_done;
         r_session_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (go) begin
                  r_ks_key        <= key;
                  r_ks_key_length <= key_length;
                  r_ks_start      <= 1'b1;
                  r_busy          <= 1'b1;
                  r_idx           <= '0;
                  r_state         <= ST_WAIT_KS;
               end
            end
            ST_WAIT_KS: begin
               // a done level left over from the last session is not an edge
               if (w_ks_rise) begin
                  r_buf      <= ks_ckey;
                  r_ks_start <= 1'b0;
                  r_state    <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (w_in_xfer) begin
                  r_m_data  <= s_data ^ w_ks_byte;
                  r_m_valid <= 1'b1;
                  r_idx     <= r_idx + 8'd1;
               end else if (w_out_take) begin
                  r_m_valid <= 1'b0;
                  if (r_idx == LAST_IDX) begin
                     r_session_done <= 1'b1;
                     r_busy         <= 1'b0;
                     r_state        <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy          = r_busy;
   assign session_done  = r_session_done;
   assign ks_start      = r_ks_start;
   assign ks_key        = r_ks_key;
   assign ks_key_length = r_ks_key_length;
   assign s_ready       = w_s_ready;
   assign m_valid       = r_m_valid;
   assign m_data        = r_m_data;

endmodule

// File: tb/tb_rc4_stream_cipher.sv
// Bench for rc4_stream_cipher: plays the keystream generator with an RC4
// model and scoreboards the ciphertext against plaintext XOR keystream.
module tb_rc4_stream_cipher;

   localparam int NB = 5;
   localparam int KW = NB * 8;

   localparam logic [KW-1:0] KV_KEY = 40'h000079654B;
   localparam logic [KW-1:0] KV_PT  = 40'h6E69616C50;
   localparam logic [KW-1:0] KV_CT  = 40'hD9E816F3BB;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            go = 1'b0;
   logic [KW-1:0]   key = '0;
   logic [7:0]      key_length = '0;
   logic            busy;
   logic            session_done;
   logic            ks_start;
   logic [KW-1:0]   ks_key;
   logic [7:0]      ks_key_length;
   logic [KW-1:0]   ks_ckey = '0;
   logic            ks_done = 1'b0;
   logic            s_valid = 1'b0;
   logic [7:0]      s_data = '0;
   logic            s_ready;
   logic            m_valid;
   logic [7:0]      m_data;
   logic            m_ready = 1'b0;
   logic [60:0]     w_outs;

   int n_cmp = 0;
   int n_bad = 0;

   rc4_stream_cipher #(.NUMS_OF_BYTES(NB)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .key(key), .key_length(key_length),
      .busy(busy), .session_done(session_done), .ks_start(ks_start),
      .ks_key(ks_key), .ks_key_length(ks_key_length), .ks_ckey(ks_ckey),
      .ks_done(ks_done), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   assign w_outs = {ks_start, ks_key, ks_key_length, busy, session_done, s_ready, m_valid, m_data};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // textbook RC4: KSA over the first len key bytes, then NB bytes of PRGA
   function automatic logic [KW-1:0] rc4_ks(input logic [KW-1:0] k, input int len);
      int s[256];
      int i, j, t;
      logic [KW-1:0] res;
      for (int n = 0; n < 256; n++) s[n] = n;
      j = 0;
      for (int n = 0; n < 256; n++) begin
         j = (j + s[n] + int'(k[(n % len)*8 +: 8])) % 256;
         t = s[n]; s[n] = s[j]; s[j] = t;
      end
      i = 0; j = 0; res = '0;
      for (int n = 0; n < NB; n++) begin
         i = (i + 1) % 256;
         j = (j + s[i]) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         res[n*8 +: 8] = 8'(s[(s[i] + s[j]) % 256]);
      end
      return res;
   endfunction

   // entered and left at a falling edge; mode 0 random, 1 full rate, 2 backpressure
   task automatic run_session(input logic [KW-1:0] k, input logic [7:0] klen,
                              input logic [KW-1:0] pt, input logic [KW-1:0] exp_ct,
                              input int mode, input int lat, input bit go_pulse,
                              input int abort_at);
      int bad, sent, recv, bp, first_c, last_c, sd_bad, sr_bad;
      go = 1'b1; key = k; key_length = klen; s_valid = 1'b0; m_ready = 1'b0;
      @(negedge clk);
      go = 1'b0;
      chk("go_busy", 64'(busy), 64'(1));
      chk("go_start", 64'(ks_start), 64'(1));
      chk("go_key", 64'(ks_key), 64'(k));
      chk("go_len", 64'(ks_key_length), 64'(klen));
      chk("done_width", 64'(session_done), 64'(0));

      bad = 0;
      if (ks_done) begin
         repeat (3) begin
            ks_ckey = KW'({$urandom, $urandom});
            @(negedge clk);
            if (ks_start !== 1'b1) bad++;
         end
         ks_done = 1'b0;
      end
      for (int c = 0; c < lat; c++) begin
         go = go_pulse && (c == 0);
         if (go) key = ~k;
         @(negedge clk);
         if (ks_start !== 1'b1 || busy !== 1'b1) bad++;
      end
      go = 1'b0;
      chk("start_hold", 64'(bad), 64'(0));
      chk("wait_key", 64'(ks_key), 64'(k));
      ks_done = 1'b1;
      ks_ckey = rc4_ks(k, int'(klen));
      @(negedge clk);
      chk("start_fall", 64'(ks_start), 64'(0));
      chk("stream_busy", 64'(busy), 64'(1));

      sent = 0; recv = 0; bp = 0; first_c = -1; last_c = -1; sd_bad = 0; sr_bad = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (mode == 0) m_ready = ($urandom_range(0, 2) != 0);
         else           m_ready = 1'b1;
         if (mode == 2 && m_valid && recv == 0 && bp < 10) begin
            m_ready = 1'b0;
            bp++;
         end
         s_valid = (sent < NB) && (mode != 0 || $urandom_range(0, 3) != 0);
         s_data  = s_valid ? pt[sent*8 +: 8] : 8'($urandom);
         go      = go_pulse && (cyc == 2);
         key     = ~k;
         #1;
         if (session_done !== 1'b0) sd_bad++;
         if (s_ready !== ((sent < NB) && (!m_valid || m_ready))) sr_bad++;
         if (mode == 2 && m_valid && !m_ready) begin
            chk("bp_hold", 64'(m_data), 64'(exp_ct[7:0]));
            chk("bp_sready", 64'(s_ready), 64'(0));
         end
         if (m_valid && m_ready) begin
            chk($sformatf("ct%0d", recv), 64'(m_data), 64'(exp_ct[recv*8 +: 8]));
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
            recv++;
         end
         if (s_valid && s_ready) sent++;
         if (recv == abort_at || recv == NB) break;
         @(negedge clk);
      end
      go = 1'b0;
      chk("done_early", 64'(sd_bad), 64'(0));
      chk("s_ready_rule", 64'(sr_bad), 64'(0));

      if (abort_at >= 0) begin
         @(posedge clk);
         #2;
         rst_n = 1'b0;
         #1;
         chk("rst_outs", 64'(w_outs), 64'(0));
         chk("rst_recv", 64'(recv), 64'(abort_at));
         ks_done = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         chk("post_rst_done", 64'(session_done), 64'(0));
         chk("post_rst_busy", 64'(busy), 64'(0));
      end else begin
         chk("recv_count", 64'(recv), 64'(NB));
         @(negedge clk);
         s_valid = 1'b0;
         chk("session_done", 64'(session_done), 64'(1));
         chk("end_busy", 64'(busy), 64'(0));
         chk("end_mvalid", 64'(m_valid), 64'(0));
         chk("end_key", 64'(ks_key), 64'(k));
         if (mode == 1) chk("tput_span", 64'(last_c - first_c), 64'(NB - 1));
      end
   endtask

   initial begin
      logic [KW-1:0] rk, rpt;
      logic [7:0]    rlen;
      #12;
      chk("reset_outs", 64'(w_outs), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_session(KV_KEY, 8'd3, KV_PT, KV_CT, 2, 4, 1'b0, -1);
      run_session(KV_KEY, 8'd3, KV_PT, KV_CT, 0, 40, 1'b1, -1);
      run_session(KV_KEY, 8'd3, KV_PT, KV_CT, 1, 2, 1'b0, -1);
      run_session(KV_KEY, 8'd3, KV_PT, KV_CT, 1, 3, 1'b0, 2);
      run_session(KV_KEY, 8'd3, KV_PT, KV_CT, 0, 5, 1'b0, -1);

      for (int r = 0; r < 20; r++) begin
         rk   = KW'({$urandom, $urandom});
         rlen = 8'($urandom_range(1, NB));
         rpt  = KW'({$urandom, $urandom});
         if ($urandom_range(0, 1) == 0) ks_done = 1'b0;
         run_session(rk, rlen, rpt, rpt ^ rc4_ks(rk, int'(rlen)),
                     int'($urandom_range(0, 2)), int'($urandom_range(1, 8)),
                     1'($urandom_range(0, 1)), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
